// File: rtl/mem_ctrl.sv
// mem_ctrl: main-memory responder behind the icache/dcache refill interface.
// Arbitrates icache line reads against dcache line reads/writebacks (dcache
// wins), waits a fixed LATENCY after accept, then pulses the owner's ack for
// one cycle with the line (reads) or after committing the line (writes).
//
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   i_req/i_addr    icache read request (level, held until i_ack)
//   i_ack/i_data    icache one-cycle ack and line data (held until next read)
//   d_req/d_we      dcache request, 1 = writeback, 0 = read
//   d_addr/d_wdata  dcache byte address and write line
//   d_ack/d_rdata   dcache one-cycle ack and read line (held until next read)
//   busy            high while a transaction is outstanding (WAIT or RESP)
//
// Build option: define MEM_CTRL_INIT_EN to power up with line i, word j =
// 4*i+j; otherwise every line powers up as zero.
module mem_ctrl #(
    parameter int unsigned LINE_W  = 128,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [LINE_W-1:0] i_data,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [LINE_W-1:0] d_rdata,
    output logic              busy
);

    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned WORDS  = LINE_W / 32;
    localparam int unsigned LADDR_W = ADDR_W - 4;
`ifdef MEM_CTRL_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

    // Power-up image of a line.
    function automatic logic [LINE_W-1:0] init_line(input logic [IDX_W-1:0] idx);
        logic [LINE_W-1:0] line;
        line = '0;
        for (int j = 0; j < int'(WORDS); j++) begin
            line[32*j +: 32] = INIT_EN ? 32'(4 * int'(idx) + j) : 32'd0;
        end
        return line;
    endfunction

    // Line index from the line-address field; out-of-range addresses wrap.
    function automatic logic [IDX_W-1:0] line_idx(input logic [LADDR_W-1:0] la);
        return IDX_W'(la % DEPTH);
    endfunction

    // Storage holds the difference from the power-up image, so a zero-filled
    // array represents the initial pattern without any load sequence.
    logic [LINE_W-1:0] mem_q [DEPTH] = '{default: '0};

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              own_d_q, own_d_d;
    logic              we_q, we_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              i_ack_q, i_ack_d, d_ack_q, d_ack_d, busy_q, busy_d;
    logic [LINE_W-1:0] i_data_q, i_data_d, d_rdata_q, d_rdata_d;
    logic [LINE_W-1:0] rd_line_c;
    logic              mem_we_c;
    logic              unused_ok;

    // Byte offset within a line is ignored.
    assign unused_ok = ^{i_addr[3:0], d_addr[3:0]};

    assign rd_line_c = mem_q[idx_q] ^ init_line(idx_q);

    // State register and latched request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            own_d_q   <= 1'b0;
            we_q      <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            busy_q    <= 1'b0;
            i_data_q  <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            own_d_q   <= own_d_d;
            we_q      <= we_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            busy_q    <= busy_d;
            i_data_q  <= i_data_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // Array write port; contents are not affected by reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[idx_q] <= wdata_q ^ init_line(idx_q);
        end
    end

    // Next-state, arbitration and access.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        own_d_d   = own_d_q;
        we_d      = we_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        i_data_d  = i_data_q;
        d_rdata_d = d_rdata_q;
        mem_we_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (d_req) begin
                    own_d_d = 1'b1;
                    we_d    = d_we;
                    idx_d   = line_idx(d_addr[ADDR_W-1:4]);
                    wdata_d = d_wdata;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = ST_WAIT;
                end else if (i_req) begin
                    own_d_d = 1'b0;
                    we_d    = 1'b0;
                    idx_d   = line_idx(i_addr[ADDR_W-1:4]);
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    if (own_d_q) begin
                        d_ack_d = 1'b1;
                        if (we_q) begin
                            mem_we_c = 1'b1;
                        end else begin
                            d_rdata_d = rd_line_c;
                        end
                    end else begin
                        i_ack_d  = 1'b1;
                        i_data_d = rd_line_c;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign i_data  = i_data_q;
    assign d_rdata = d_rdata_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus pushes expected acks, a negedge
// monitor pops and checks port, ack cycle, data and busy.
module tb_mem_ctrl;

    localparam int unsigned LINE_W = 128;
    localparam int unsigned ADDR_W = 32;
    localparam int LAT = 5;
`ifdef MEM_CTRL_INIT_EN
    localparam bit INIT = 1'b1;
`else
    localparam bit INIT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              i_req = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic              i_ack;
    logic [LINE_W-1:0] i_data;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [LINE_W-1:0] d_wdata = '0;
    logic              d_ack;
    logic [LINE_W-1:0] d_rdata;
    logic              busy;

    mem_ctrl #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .DEPTH(256), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_data(i_data),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .busy(busy)
    );

    typedef struct {
        bit                is_d;
        logic [LINE_W-1:0] data;
        int                cyc;
        string             name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   prev_ack = 1'b0;
    int   e0;
    logic [LINE_W-1:0] d_last = '0;

    localparam logic [LINE_W-1:0] DB = {4{32'hDEADBEEF}};
    localparam logic [LINE_W-1:0] W2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected power-up line whose word 0 holds w0.
    function automatic logic [LINE_W-1:0] pat(input int unsigned w0);
        return INIT ? {32'(w0 + 3), 32'(w0 + 2), 32'(w0 + 1), 32'(w0)} : '0;
    endfunction

    task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic expect_ack(input bit is_d, input logic [LINE_W-1:0] data, input int c, input string nm);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        e.cyc  = c;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic raise_i(input logic [ADDR_W-1:0] a);
        i_addr = a;
        i_req  = 1'b1;
    endtask

    task automatic raise_d(input bit we, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] wd);
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
    endtask

    // Hold requests until acked, dropping each on the cycle its ack is seen.
    task automatic wait_done();
        int n = 0;
        while ((i_req || d_req) && n < 40) begin
            @(negedge clk);
            n++;
            if (i_ack) i_req = 1'b0;
            if (d_ack) d_req = 1'b0;
        end
        n_chk++;
        if (i_req || d_req) begin
            n_fail++;
            $display("FAIL ack_timeout: i_req=%0b d_req=%0b still pending at cycle %0d", i_req, d_req, cyc);
            i_req = 1'b0;
            d_req = 1'b0;
        end
    endtask

    // Monitor: every ack must match the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            prev_ack = 1'b0;
        end else begin
            if (prev_ack) begin
                chk("busy_after_resp", LINE_W'(busy), '0);
                chk("ack_one_cycle", LINE_W'(i_ack | d_ack), '0);
            end
            if (i_ack && d_ack) chk("acks_exclusive", LINE_W'(i_ack & d_ack), '0);
            if (i_ack || d_ack) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", LINE_W'({i_ack, d_ack}), '0);
                end else begin
                    mon_e = sb.pop_front();
                    chk({mon_e.name, "_port"}, LINE_W'(d_ack), LINE_W'(mon_e.is_d));
                    chk({mon_e.name, "_cycle"}, LINE_W'(cyc), LINE_W'(mon_e.cyc));
                    chk({mon_e.name, "_data"}, mon_e.is_d ? d_rdata : i_data, mon_e.data);
                    chk({mon_e.name, "_busy"}, LINE_W'(busy), LINE_W'(1));
                end
            end
            prev_ack = i_ack || d_ack;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_i_ack", LINE_W'(i_ack), '0);
        chk("rst_d_ack", LINE_W'(d_ack), '0);
        chk("rst_busy", LINE_W'(busy), '0);
        chk("rst_i_data", i_data, '0);
        chk("rst_d_rdata", d_rdata, '0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // icache read of line 2
        e0 = cyc + 1;
        expect_ack(1'b0, pat(8), e0 + LAT, "i_rd_0x20");
        raise_i(32'h20);
        wait_done();
        repeat (2) @(negedge clk);

        // dcache writeback; inputs disturbed after accept must be ignored
        e0 = cyc + 1;
        expect_ack(1'b1, d_last, e0 + LAT, "d_wr_0x40");
        raise_d(1'b1, 32'h40, DB);
        repeat (2) @(negedge clk);
        d_addr  = 32'h50;
        d_wdata = '0;
        wait_done();
        expect_ack(1'b1, DB, e0 + 12, "d_rd_0x40");
        d_last = DB;
        raise_d(1'b0, 32'h40, '0);
        wait_done();
        repeat (2) @(negedge clk);

        // simultaneous requests: dcache first, icache at next IDLE
        e0 = cyc + 1;
        expect_ack(1'b1, pat(4), e0 + LAT, "d_rd_0x10_prio");
        expect_ack(1'b0, pat(0), e0 + 12, "i_rd_0x0_lost");
        d_last = pat(4);
        raise_i(32'h0);
        raise_d(1'b0, 32'h10, '0);
        wait_done();
        repeat (2) @(negedge clk);

        // reset during WAIT aborts the read
        e0 = cyc + 1;
        raise_d(1'b0, 32'h30, '0);
        while (cyc < e0 + 2) @(negedge clk);
        #1;
        reset = 1'b0;
        d_req = 1'b0;
        #1;
        chk("midrst_busy", LINE_W'(busy), '0);
        chk("midrst_acks", LINE_W'({i_ack, d_ack}), '0);
        chk("midrst_i_data", i_data, '0);
        chk("midrst_d_rdata", d_rdata, '0);
        d_last = '0;
        @(negedge clk);
        #1;
        reset = 1'b1;
        repeat (10) @(negedge clk);
        chk("postrst_busy", LINE_W'(busy), '0);

        // reissue, then confirm the writeback survived reset
        e0 = cyc + 1;
        expect_ack(1'b1, pat(12), e0 + LAT, "d_rd_0x30_reissue");
        d_last = pat(12);
        raise_d(1'b0, 32'h30, '0);
        wait_done();
        expect_ack(1'b0, DB, e0 + 12, "i_rd_0x40_kept");
        raise_i(32'h40);
        wait_done();
        repeat (2) @(negedge clk);

        // line 5 untouched by the post-accept address change
        e0 = cyc + 1;
        expect_ack(1'b1, pat(20), e0 + LAT, "d_rd_0x50");
        d_last = pat(20);
        raise_d(1'b0, 32'h50, '0);
        wait_done();
        repeat (1) @(negedge clk);

        // address wrap onto line 0
        e0 = cyc + 1;
        expect_ack(1'b1, pat(0), e0 + LAT, "d_rd_0x100f_wrap");
        d_last = pat(0);
        raise_d(1'b0, 32'h100F, '0);
        wait_done();
        expect_ack(1'b1, pat(0), e0 + 12, "d_rd_0x0");
        raise_d(1'b0, 32'h0, '0);
        wait_done();
        repeat (3) @(negedge clk);

        // write through an aliased address, read back through another
        e0 = cyc + 1;
        expect_ack(1'b1, d_last, e0 + LAT, "d_wr_0x1230");
        raise_d(1'b1, 32'h1230, W2);
        wait_done();
        expect_ack(1'b0, W2, e0 + 12, "i_rd_0x238_alias");
        raise_i(32'h238);
        wait_done();
        expect_ack(1'b1, W2, e0 + 19, "d_rd_0x230");
        d_last = W2;
        raise_d(1'b0, 32'h230, '0);
        wait_done();
        repeat (4) @(negedge clk);

        chk("scoreboard_drained", LINE_W'(sb.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Main-memory responder at the far end of the cache refill interface. It serves line-fill reads from the instruction cache and line reads/writebacks from the data cache, arbitrating between the two, modelling a fixed access latency, and returning one full line per transaction. It sits below icache/dcache in the processor, replacing ad-hoc memory arrays with a single handshaked backing store.

## Interface
- LINE_W, 128, line width in bits (4 × 32-bit words; word j in bits [32j+31:32j])
- ADDR_W, 32, byte-address width
- DEPTH, 256, number of lines stored
- LATENCY, 5, cycles from request accept to ack (≥1)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  icache read request, level, held until i_ack
- i_addr  in  ADDR_W  icache byte address
- i_ack  out  1  one-cycle response pulse to icache
- i_data  out  LINE_W  icache line data, valid with i_ack
- d_req  in  1  dcache request, level, held until d_ack
- d_we  in  1  1 = line write (writeback), 0 = line read
- d_addr  in  ADDR_W  dcache byte address
- d_wdata  in  LINE_W  dcache write line
- d_ack  out  1  one-cycle response pulse to dcache
- d_rdata  out  LINE_W  dcache read line, valid with d_ack
- busy  out  1  high while a transaction is outstanding (WAIT or RESP)

## Operation
- Reset (reset=0, async): state IDLE, i_ack=0, d_ack=0, i_data=0, d_rdata=0, busy=0, counter=0. Array contents are not touched by reset.
- Line index = addr[ADDR_W-1:4] mod DEPTH; addr[3:0] ignored; out-of-range addresses wrap.
- FSM: IDLE, WAIT, RESP.
  - IDLE: if d_req → accept dcache (latch d_we, index, d_wdata, owner=D); else if i_req → accept icache (owner=I). Load counter=LATENCY-1, go WAIT. Neither → stay.
  - WAIT: counter==0 → go RESP and perform access; else decrement.
  - RESP: the ack for owner is high this cycle; next edge → IDLE, ack drops.
- Access on the WAIT→RESP edge: read → owner's data output loaded with line; write → array line updated from latched wdata, d_rdata unchanged. Write ack still pulsed.
- Priority fixed: dcache over icache. Losing request stays pending and is accepted at the next IDLE sample.
- Data outputs hold their last value until overwritten by the next read ack for that port.
- Request inputs are ignored in WAIT and RESP; address/wdata changes after accept have no effect.
- Requester protocol: deassert req on the edge at which it samples ack=1.

## Timing
- Accept at edge E0; ack high from edge E0+LATENCY to E0+LATENCY+1 (exactly one cycle).
- State returns to IDLE at E0+LATENCY+1; earliest next accept E0+LATENCY+2. Back-to-back period = LATENCY+2 cycles.
- LATENCY=1: WAIT lasts one cycle, ack at E0+1.
- busy rises at E0, falls at E0+LATENCY+1.
- Reset mid-transaction: transaction aborted, no ack ever issued for it, pending write not committed if reset precedes the WAIT→RESP edge; requester must reissue.

## Configuration
- MEM_CTRL_INIT_EN defined: at time 0, line i word j initialised to 4·i+j (deterministic pattern for benches).
- Not defined: all lines initialised to zero.

## Test plan
- MEM_CTRL_INIT_EN, defaults: i_req, i_addr=0x20 accepted at E0 → i_ack high only at E0+5, i_data words {8,9,10,11} (j=0..3), busy low at E0+6.
- d write d_addr=0x40, d_wdata=4×0xDEADBEEF → d_ack at E0+5, d_rdata unchanged; then d read 0x40 accepted at E0+7 → d_ack at E0+12, d_rdata=4×0xDEADBEEF.
- i_req addr 0x0 and d_req read addr 0x10 raised same cycle at E0 → d_ack at E0+5 with {4,5,6,7}; i_ack at E0+12 with {0,1,2,3}; never both acks high together.
- Read line 3 accepted at E0, reset low at E0+3 for one cycle → i_ack/d_ack stay 0, busy 0, outputs 0; reissued read after release returns {12,13,14,15}; earlier written line 0x40 still reads 0xDEADBEEF.
- Wrap: d read addr 0x100F (line 256, low nibble set) → d_rdata {0,1,2,3}, identical to addr 0x0.
- MEM_CTRL_INIT_EN undefined: read any address → line all zeros, ack at E0+5.
